// File: rtl/array_order_check.sv
// Scans an external array through a combinational read port and reports whether it is ordered.
// Define ORDER_CHECK_COUNT_EN to scan the full array and count every inverted adjacent pair.
module array_order_check #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 8,
   parameter bit SIGNED     = 1'b0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  go,
   input  logic [ADDR_WIDTH-1:0] length,
   input  logic [1:0]            mode,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [WIDTH-1:0]      rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  sorted,
   output logic [ADDR_WIDTH-1:0] inv_index,
   output logic [ADDR_WIDTH-1:0] inv_count
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_FIRST = 3'd2,
      S_SCAN  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] len_q, len_d;
   logic [1:0]            mode_q, mode_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [WIDTH-1:0]      prev_q, prev_d;
   logic                  sorted_q, sorted_d;
   logic [ADDR_WIDTH-1:0] inv_index_q, inv_index_d;
   logic                  found_q, found_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  inv;
`ifdef ORDER_CHECK_COUNT_EN
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
`endif

   // One extra bit lets a single signed comparator serve both signed and unsigned elements.
   function automatic logic is_inverted(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                        input logic [1:0] m);
      logic signed [WIDTH:0] ea;
      logic signed [WIDTH:0] eb;
      logic                  lt;
      logic                  eq;
      logic                  r;
      ea = SIGNED ? {a[WIDTH-1], a} : {1'b0, a};
      eb = SIGNED ? {b[WIDTH-1], b} : {1'b0, b};
      lt = (ea < eb);
      eq = (a == b);
      case (m)
         2'b00:   r = !lt && !eq;
         2'b10:   r = !lt;
         2'b01:   r = lt;
         default: r = lt || eq;
      endcase
      return r;
   endfunction

   assign inv = is_inverted(prev_q, rd_data, mode_q);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      mode_d      = mode_q;
      idx_d       = idx_q;
      prev_d      = prev_q;
      sorted_d    = sorted_q;
      inv_index_d = inv_index_q;
      found_d     = found_q;
`ifdef ORDER_CHECK_COUNT_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (go) begin
               state_d     = S_ARM;
               sorted_d    = 1'b0;
               inv_index_d = '0;
               found_d     = 1'b0;
`ifdef ORDER_CHECK_COUNT_EN
               cnt_d       = '0;
`endif
            end
         end
         S_ARM: begin
            len_d       = length;
            mode_d      = mode;
            sorted_d    = 1'b0;
            inv_index_d = '0;
            found_d     = 1'b0;
            idx_d       = '0;
`ifdef ORDER_CHECK_COUNT_EN
            cnt_d       = '0;
`endif
            if (!go) begin
               if (length < ADDR_WIDTH'(2)) begin
                  state_d  = S_DONE;
                  sorted_d = 1'b1;
               end else begin
                  state_d = S_FIRST;
               end
            end
         end
         S_FIRST: begin
            prev_d  = rd_data;
            idx_d   = ADDR_WIDTH'(1);
            state_d = S_SCAN;
         end
         S_SCAN: begin
            prev_d = rd_data;
            if (inv) begin
               found_d = 1'b1;
               if (!found_q) inv_index_d = idx_q;
`ifdef ORDER_CHECK_COUNT_EN
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
`endif
            end
`ifndef ORDER_CHECK_COUNT_EN
            if (inv) begin
               state_d  = S_DONE;
               sorted_d = 1'b0;
            end else
`endif
            if (idx_q == len_q - 1'b1) begin
               state_d  = S_DONE;
               sorted_d = !(found_q || inv);
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they come straight from flops.
   always_comb begin
      busy_d    = (state_d == S_ARM) || (state_d == S_FIRST) || (state_d == S_SCAN);
      done_d    = (state_d == S_DONE);
      rd_addr_d = (state_d == S_SCAN) ? idx_d : '0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         mode_q      <= '0;
         idx_q       <= '0;
         prev_q      <= '0;
         sorted_q    <= 1'b0;
         inv_index_q <= '0;
         found_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rd_addr_q   <= '0;
`ifdef ORDER_CHECK_COUNT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         mode_q      <= mode_d;
         idx_q       <= idx_d;
         prev_q      <= prev_d;
         sorted_q    <= sorted_d;
         inv_index_q <= inv_index_d;
         found_q     <= found_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rd_addr_q   <= rd_addr_d;
`ifdef ORDER_CHECK_COUNT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign sorted    = sorted_q;
   assign inv_index = inv_index_q;
   assign rd_addr   = rd_addr_q;
`ifdef ORDER_CHECK_COUNT_EN
   assign inv_count = cnt_q;
`else
   assign inv_count = {{(ADDR_WIDTH-1){1'b0}}, found_q};
`endif

endmodule

// File: tb/tb_array_order_check.sv
// Scoreboard bench for array_order_check: signed 8-bit elements, 4-bit index.
module tb_array_order_check;

   localparam int W  = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          go = 1'b0;
   logic [AW-1:0] length = '0;
   logic [1:0]    mode = '0;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  rd_data;
   logic          busy, done, sorted;
   logic [AW-1:0] inv_index, inv_count;

   logic signed [W-1:0] mem [16];
   logic signed [W-1:0] dq [$];

   typedef struct {
      logic        sorted;
      int          inv_index;
      int          inv_count;
      int          lat;
   } exp_t;
   exp_t sb [$];

   int checks = 0;
   int failures = 0;

   array_order_check #(.WIDTH(W), .ADDR_WIDTH(AW), .SIGNED(1'b1)) u_dut (
      .clock(clk), .reset(reset), .go(go), .length(length), .mode(mode),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
      .sorted(sorted), .inv_index(inv_index), .inv_count(inv_count)
   );

   assign rd_data = mem[rd_addr];

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic bit pair_inv(input int a, input int b, input logic [1:0] md);
      case (md)
         2'b00:   return a > b;
         2'b10:   return a >= b;
         2'b01:   return a < b;
         default: return a <= b;
      endcase
   endfunction

   task automatic load_mem();
      for (int i = 0; i < 16; i++) mem[i] = (i < dq.size()) ? dq[i] : '0;
   endtask

   // Edge counts are measured from the go release, taken just after a falling edge.
   task automatic run(input string name, input int len, input logic [1:0] md, input bit poke);
      exp_t e;
      bit   found;
      int   n;
      bit   rd_nz;
      bit   busy_ok;
      found = 0;
      e.inv_index = 0;
      e.inv_count = 0;
      e.lat = (len < 2) ? 1 : len + 1;
      for (int i = 1; i < len; i++) begin
         if (pair_inv(int'(dq[i-1]), int'(dq[i]), md)) begin
            if (!found) begin
               e.inv_index = i;
`ifndef ORDER_CHECK_COUNT_EN
               e.lat = i + 2;
`endif
            end
            found = 1;
            e.inv_count++;
         end
      end
`ifndef ORDER_CHECK_COUNT_EN
      e.inv_count = found ? 1 : 0;
`endif
      e.sorted = !found;
      load_mem();

      @(negedge clk);
      length = AW'(len);
      mode = md;
      go = 1'b1;
      @(negedge clk);
      check({name, "_arm_busy"}, busy, 1);
      check({name, "_arm_done"}, done, 0);
      check({name, "_arm_cnt"}, inv_count, 0);
      check({name, "_arm_sorted"}, sorted, 0);
      @(negedge clk);
      go = 1'b0;
      sb.push_back(e);

      n = 0;
      rd_nz = 0;
      busy_ok = 1;
      do begin
         @(negedge clk);
         n++;
         if (rd_addr != '0) rd_nz = 1;
         if (!done && !busy) busy_ok = 0;
         if (poke && !done) go = (n == 2);
      end while (!done && n < 100);
      go = 1'b0;

      if (!done) begin
         check({name, "_timeout"}, 0, 1);
         void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         check({name, "_latency"}, n, e.lat);
         check({name, "_sorted"}, sorted, e.sorted);
         check({name, "_inv_index"}, inv_index, e.inv_index);
         check({name, "_inv_count"}, inv_count, e.inv_count);
         check({name, "_busy_off"}, busy, 0);
         check({name, "_busy_run"}, busy_ok, 1);
         if (len < 2) check({name, "_no_read"}, rd_nz, 0);
         repeat (3) @(negedge clk);
         check({name, "_hold_done"}, done, 1);
         check({name, "_hold_sorted"}, sorted, e.sorted);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sorted", sorted, 0);
      check("rst_inv_index", inv_index, 0);
      check("rst_inv_count", inv_count, 0);
      check("rst_rd_addr", rd_addr, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_done", done, 0);

      dq = '{8'sd1, 8'sd2, 8'sd2, 8'sd7, 8'sd9};
      run("asc_ns", 5, 2'b00, 1'b1);
      dq = '{8'sd1, 8'sd2, 8'sd2, 8'sd7};
      run("asc_st", 4, 2'b10, 1'b0);
      dq = '{8'sd5, 8'sd0, -8'sd3, -8'sd3, -8'sd128};
      run("desc_ns", 5, 2'b01, 1'b0);
      run("desc_st", 5, 2'b11, 1'b0);
      dq = '{8'sd4, 8'sd3, 8'sd2, 8'sd1, 8'sd5, 8'sd0};
      run("multi", 6, 2'b00, 1'b0);
      dq = '{-8'sd128, -8'sd1, 8'sd0, 8'sd127};
      run("signed_asc", 4, 2'b10, 1'b0);
      dq = '{8'sd9, 8'sd5, 8'sd1, 8'sd0, -8'sd7};
      run("desc_poke", 5, 2'b11, 1'b1);
      dq = '{8'sd7, 8'sd3};
      run("len0", 0, 2'b00, 1'b0);
      run("len1", 1, 2'b00, 1'b0);

      // Reset in the middle of a length-8 scan.
      dq = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8};
      load_mem();
      @(negedge clk);
      length = AW'(8);
      mode = 2'b00;
      go = 1'b1;
      repeat (2) @(negedge clk);
      go = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_busy_before", busy, 1);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_sorted", sorted, 0);
      check("mid_rst_inv_index", inv_index, 0);
      check("mid_rst_inv_count", inv_count, 0);
      check("mid_rst_rd_addr", rd_addr, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("no_autostart_busy", busy, 0);
      check("no_autostart_done", done, 0);
      dq = '{8'sd1, 8'sd2};
      run("after_rst", 2, 2'b00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
